// File: rtl/blake_pkg.sv
// Shared BLAKE constants, G rotation amounts and the G engine state encoding.
package blake_pkg;

    localparam int ROT64_0 = 32;
    localparam int ROT64_1 = 25;
    localparam int ROT64_2 = 16;
    localparam int ROT64_3 = 11;

    localparam int ROT32_0 = 16;
    localparam int ROT32_1 = 12;
    localparam int ROT32_2 = 8;
    localparam int ROT32_3 = 7;

    localparam logic [31:0] IV256 [8] = '{
        32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
        32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19
    };

    localparam logic [31:0] CST256 [16] = '{
        32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
        32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
        32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
        32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917
    };

    localparam logic [63:0] IV512 [8] = '{
        64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B,
        64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1,
        64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F,
        64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179
    };

    localparam logic [63:0] CST512 [16] = '{
        64'h243F6A8885A308D3, 64'h13198A2E03707344,
        64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
        64'h452821E638D01377, 64'hBE5466CF34E90C6C,
        64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
        64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC,
        64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
        64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7,
        64'h0801F2E2858EFC16, 64'h636920D871574E69
    };

    typedef enum logic [1:0] {IDLE, S1, S2, OUT} g_state_e;

endpackage

// File: rtl/blake_g_half.sv
// One G half-step: add/xor/rotate chain with run-time selectable rotation amounts.
module blake_g_half #(
    parameter int W  = 64,
    parameter int RW = $clog2(W)
) (
    input  logic [W-1:0]  a_i,
    input  logic [W-1:0]  b_i,
    input  logic [W-1:0]  c_i,
    input  logic [W-1:0]  d_i,
    input  logic [W-1:0]  x_i,
    input  logic [RW-1:0] ra_i,
    input  logic [RW-1:0] rb_i,
    output logic [W-1:0]  a_o,
    output logic [W-1:0]  b_o,
    output logic [W-1:0]  c_o,
    output logic [W-1:0]  d_o
);

    function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input logic [RW-1:0] n);
        return (v >> n) | (v << (W - int'(n)));
    endfunction

    assign a_o = a_i + b_i + x_i;
    assign d_o = rotr(d_i ^ a_o, ra_i);
    assign c_o = c_i + d_o;
    assign b_o = rotr(b_i ^ c_o, rb_i);

endmodule

// File: rtl/blake_g_engine.sv
// Two-cycle sequential BLAKE G (W=64: BLAKE-512, W=32: BLAKE-256) with valid/ready on both sides.
// Optional mid-state taps are enabled with `define BLAKE_G_MIDSTATE_EN.
module blake_g_engine
    import blake_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic [W-1:0] c_in,
    input  logic [W-1:0] d_in,
    input  logic [W-1:0] msg_j,
    input  logic [W-1:0] msg_k,
    input  logic [W-1:0] cst_j,
    input  logic [W-1:0] cst_k,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] a_out,
    output logic [W-1:0] b_out,
    output logic [W-1:0] c_out,
    output logic [W-1:0] d_out
`ifdef BLAKE_G_MIDSTATE_EN
    ,
    output logic         mid_valid,
    output logic [W-1:0] mid_a,
    output logic [W-1:0] mid_b,
    output logic [W-1:0] mid_c,
    output logic [W-1:0] mid_d
`endif
);

    generate
        if (W != 32 && W != 64) begin : g_bad_w
            $error("blake_g_engine: W must be 32 or 64");
        end
    endgenerate

    localparam int RW = $clog2(W);
    localparam int R0 = (W == 64) ? ROT64_0 : ROT32_0;
    localparam int R1 = (W == 64) ? ROT64_1 : ROT32_1;
    localparam int R2 = (W == 64) ? ROT64_2 : ROT32_2;
    localparam int R3 = (W == 64) ? ROT64_3 : ROT32_3;

    g_state_e       state_q;
    logic [W-1:0]   a_q, b_q, c_q, d_q, x1_q, x2_q;
    logic [W-1:0]   ao_q, bo_q, co_q, do_q;
    logic           out_valid_q;
    logic [W-1:0]   a_d, b_d, c_d, d_d;
    logic           is_s1;
    logic           acc;

    assign in_ready = (state_q == IDLE) || (state_q == OUT && out_ready);
    assign acc      = in_valid && in_ready;
    assign is_s1    = (state_q == S1);

    // A single half-step datapath serves both edges; S1 and S2 only differ in x and rotations.
    blake_g_half #(.W(W)) u_half (
        .a_i  (a_q),
        .b_i  (b_q),
        .c_i  (c_q),
        .d_i  (d_q),
        .x_i  (is_s1 ? x1_q : x2_q),
        .ra_i (is_s1 ? RW'(R0) : RW'(R2)),
        .rb_i (is_s1 ? RW'(R1) : RW'(R3)),
        .a_o  (a_d),
        .b_o  (b_d),
        .c_o  (c_d),
        .d_o  (d_d)
    );

`ifdef BLAKE_G_MIDSTATE_EN
    logic         mid_valid_q;
    logic [W-1:0] ma_q, mb_q, mc_q, md_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mid_valid_q <= 1'b0;
            ma_q        <= '0;
            mb_q        <= '0;
            mc_q        <= '0;
            md_q        <= '0;
        end else begin
            mid_valid_q <= is_s1;
            if (is_s1) begin
                ma_q <= a_d;
                mb_q <= b_d;
                mc_q <= c_d;
                md_q <= d_d;
            end
        end
    end

    assign mid_valid = mid_valid_q;
    assign mid_a     = ma_q;
    assign mid_b     = mb_q;
    assign mid_c     = mc_q;
    assign mid_d     = md_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            ao_q        <= '0;
            bo_q        <= '0;
            co_q        <= '0;
            do_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S1: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    c_q     <= c_d;
                    d_q     <= d_d;
                    state_q <= S2;
                end
                S2: begin
                    ao_q        <= a_d;
                    bo_q        <= b_d;
                    co_q        <= c_d;
                    do_q        <= d_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                default: begin
                    // IDLE or OUT; result words stay put until the next S2 edge
                    if (state_q == OUT && out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                    if (acc) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        c_q     <= c_in;
                        d_q     <= d_in;
                        x1_q    <= msg_j ^ cst_k;
                        x2_q    <= msg_k ^ cst_j;
                        state_q <= S1;
                    end
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign a_out     = ao_q;
    assign b_out     = bo_q;
    assign c_out     = co_q;
    assign d_out     = do_q;

endmodule

// File: tb/tb_blake_g_engine.sv
// Scoreboard bench for blake_g_engine: a W=64 and a W=32 instance against a word-level G model.
module tb_blake_g_engine;

    typedef struct packed {
        logic [63:0] a, b, c, d, mj, mk, cj, ck;
    } op_t;

    typedef struct packed {
        logic [63:0] a, b, c, d;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] in_valid = 2'b00;
    logic [1:0] out_ready = 2'b11;
    logic [1:0] in_ready;
    logic [1:0] out_valid;
    op_t        op = '0;
    logic [63:0] a64, b64, c64, d64;
    logic [31:0] a32, b32, c32, d32;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    res_t       exp_q [2][$];
    int         pop_cyc [$];

`ifdef BLAKE_G_MIDSTATE_EN
    logic [1:0]  mid_valid;
    logic [63:0] ma64, mb64, mc64, md64;
    logic [31:0] ma32, mb32, mc32, md32;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    blake_g_engine #(.W(64)) u64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a_in(op.a), .b_in(op.b), .c_in(op.c), .d_in(op.d),
        .msg_j(op.mj), .msg_k(op.mk), .cst_j(op.cj), .cst_k(op.ck),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .a_out(a64), .b_out(b64), .c_out(c64), .d_out(d64)
`ifdef BLAKE_G_MIDSTATE_EN
        , .mid_valid(mid_valid[0]), .mid_a(ma64), .mid_b(mb64), .mid_c(mc64), .mid_d(md64)
`endif
    );

    blake_g_engine #(.W(32)) u32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a_in(op.a[31:0]), .b_in(op.b[31:0]), .c_in(op.c[31:0]), .d_in(op.d[31:0]),
        .msg_j(op.mj[31:0]), .msg_k(op.mk[31:0]), .cst_j(op.cj[31:0]), .cst_k(op.ck[31:0]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .a_out(a32), .b_out(b32), .c_out(c32), .d_out(d32)
`ifdef BLAKE_G_MIDSTATE_EN
        , .mid_valid(mid_valid[1]), .mid_a(ma32), .mid_b(mb32), .mid_c(mc32), .mid_d(md32)
`endif
    );

    // ---- reference model: BLAKE G on w-bit words held in 64-bit containers ----
    function automatic logic [63:0] rotr(int w, logic [63:0] v, int n);
        logic [63:0] m;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        return ((v >> n) | (v << (w - n))) & m;
    endfunction

    function automatic res_t gref(int w, op_t o);
        logic [63:0] m, a, b, c, d, x;
        int rot [4];
        res_t r;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        rot[0] = w / 2;
        rot[1] = (w == 64) ? 25 : 12;
        rot[2] = w / 4;
        rot[3] = (w == 64) ? 11 : 7;
        a = o.a & m; b = o.b & m; c = o.c & m; d = o.d & m;
        for (int h = 0; h < 2; h++) begin
            x = ((h == 0) ? (o.mj ^ o.ck) : (o.mk ^ o.cj)) & m;
            a = (a + b + x) & m;
            d = rotr(w, d ^ a, rot[2*h]);
            c = (c + d) & m;
            b = rotr(w, b ^ c, rot[2*h+1]);
        end
        r.a = a; r.b = b; r.c = c; r.d = d;
        return r;
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        o.a  = {$urandom, $urandom}; o.b  = {$urandom, $urandom};
        o.c  = {$urandom, $urandom}; o.d  = {$urandom, $urandom};
        o.mj = {$urandom, $urandom}; o.mk = {$urandom, $urandom};
        o.cj = {$urandom, $urandom}; o.ck = {$urandom, $urandom};
        return o;
    endfunction

    function automatic res_t got(int d);
        res_t r;
        if (d == 0) begin
            r.a = a64; r.b = b64; r.c = c64; r.d = d64;
        end else begin
            r.a = {32'h0, a32}; r.b = {32'h0, b32}; r.c = {32'h0, c32}; r.d = {32'h0, d32};
        end
        return r;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // ---- monitor: pop and compare on every output handshake ----
    always @(negedge clk) begin
        res_t e, g;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (out_valid[d] && out_ready[d]) begin
                    g = got(d);
                    if (exp_q[d].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result dut%0d: got a=%h, required no result", d, g.a);
                    end else begin
                        e = exp_q[d].pop_front();
                        chk($sformatf("res%0d.a", d), g.a, e.a);
                        chk($sformatf("res%0d.b", d), g.b, e.b);
                        chk($sformatf("res%0d.c", d), g.c, e.c);
                        chk($sformatf("res%0d.d", d), g.d, e.d);
                        if (d == 0) pop_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    // ---- stimulus ----
    task automatic send(int d, op_t o);
        int n;
        n = 0;
        op = o;
        in_valid[d] = 1'b1;
        @(negedge clk);
        while (!in_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[d]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout dut%0d: in_ready=%0b, required 1", d, in_ready[d]);
            in_valid[d] = 1'b0;
            return;
        end
        exp_q[d].push_back(gref((d == 0) ? 64 : 32, o));
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        op = rnd_op();  // post-accept input changes must not leak into the result
    endtask

    task automatic drain(int d);
        int n;
        n = 0;
        while (exp_q[d].size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_q[d].size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout dut%0d: pending=%0d, required 0", d, exp_q[d].size());
            exp_q[d].delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        op_t  v, v2;
        res_t e;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_out_valid64", 64'(out_valid[0]), 64'd0);
        chk("rst_out_valid32", 64'(out_valid[1]), 64'd0);
        chk("rst_in_ready64", 64'(in_ready[0]), 64'd1);
        chk("rst_in_ready32", 64'(in_ready[1]), 64'd1);
        chk("rst_a64", a64, 64'd0);
        chk("rst_d64", d64, 64'd0);
        chk("rst_b32", 64'(b32), 64'd0);
        @(posedge clk);
        #1;

        // known-answer vector with latency check
        v.a  = 64'h6a09e667f3bcc908; v.b  = 64'h510e527fade682d1;
        v.c  = 64'h243f6a8885a308d3; v.d  = 64'h452821e638d011f7;
        v.mj = 64'h00000020b7f3f008; v.mk = 64'haafa9c96f2018962;
        v.cj = 64'h243f6a8885a308d3; v.ck = 64'h13198a2e03707344;
        send(0, v);
        @(posedge clk);
        #1;
        chk("kat_valid_early", 64'(out_valid[0]), 64'd0);
`ifdef BLAKE_G_MIDSTATE_EN
        chk("kat_mid_valid", 64'(mid_valid[0]), 64'd1);
        chk("kat_mid_a", ma64, 64'hce31c2f65626cf25);
        chk("kat_mid_b", mb64, 64'had3499611c0d925e);
        chk("kat_mid_c", mc64, 64'h9336495b10bcebe3);
        chk("kat_mid_d", md64, 64'h6ef6ded28b19e310);
`endif
        @(posedge clk);
        #1;
        chk("kat_valid", 64'(out_valid[0]), 64'd1);
        chk("kat_a", a64, 64'h0a2c5275e9d6e334);
        chk("kat_b", b64, 64'h9d87cdc6ea902d3b);
        chk("kat_c", c64, 64'h935aae359d644eb2);
        chk("kat_d", d64, 64'h002464da8ca762cf);
        drain(0);

        // all-zero operands on both widths
        send(0, '0);
        drain(0);
        send(1, '0);
        drain(1);

        // backpressure: result held, second vector waits, then accepted with out_ready
        out_ready[0] = 1'b0;
        v = rnd_op();
        e = gref(64, v);
        send(0, v);
        repeat (2) @(posedge clk);
        #1;
        v2 = rnd_op();
        op = v2;
        in_valid[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready[0]), 64'd0);
            chk("bp_out_valid", 64'(out_valid[0]), 64'd1);
            chk("bp_a", a64, e.a);
            chk("bp_d", d64, e.d);
            @(posedge clk);
            #1;
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_accept", 64'(in_ready[0]), 64'd1);
        exp_q[0].push_back(gref(64, v2));
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        op = rnd_op();
        drain(0);

        // back-to-back throughput
        pop_cyc.delete();
        for (int i = 0; i < 10; i++) send(0, rnd_op());
        drain(0);
        chk("b2b_count", 64'(pop_cyc.size()), 64'd10);
        for (int i = 1; i < pop_cyc.size(); i++)
            chk("b2b_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd3);

        // asynchronous reset while in S2
        send(0, rnd_op());
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid[0]), 64'd0);
        chk("arst_a", a64, 64'd0);
        chk("arst_b", b64, 64'd0);
        chk("arst_c", c64, 64'd0);
        chk("arst_d", d64, 64'd0);
        exp_q[0].delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("arst_in_ready", 64'(in_ready[0]), 64'd1);
        @(posedge clk);
        #1;
        send(0, rnd_op());
        drain(0);

        // randomized vectors
        repeat (200) send(0, rnd_op());
        drain(0);
        repeat (1000) send(1, rnd_op());
        drain(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule
